// File: rtl/flight_sequencer_if.sv
`timescale 1ns/1ps
// flight_sequencer_if: command handshake between a command source and the
// flight sequencer. A command transfers on an edge where cmd_valid && cmd_ready.
interface flight_sequencer_if;
  logic       cmd_valid;
  logic [2:0] cmd_code;
  logic       cmd_ready;

  modport master (output cmd_valid, output cmd_code, input cmd_ready);
  modport slave  (input cmd_valid, input cmd_code, output cmd_ready);
endinterface

// File: rtl/flight_sequencer.sv
`timescale 1ns/1ps
// flight_sequencer: drives the one-hot mode_sel/pos_sel selects of the x/y/z
// position units. It issues the zeroing cycle after reset, takes flight
// commands, and runs the charge / warp / cooldown sequence.
// Optional feature: define FLIGHT_SEQ_WARP_COUNT_EN to build the saturating
// warp_count counter; otherwise warp_count is tied to 0.
module flight_sequencer #(
  parameter int CHARGE_CYCLES   = 8,
  parameter int COOLDOWN_CYCLES = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  flight_sequencer_if.slave cmd,
  input  logic              abort,
  output logic [3:0]        mode_sel,
  output logic [3:0]        pos_sel,
  output logic [2:0]        state,
  output logic              busy,
  output logic              cmd_err,
  output logic [7:0]        warp_count
);
  typedef enum logic [2:0] {
    ZERO     = 3'd0,
    PARK     = 3'd1,
    CRUISE   = 3'd2,
    CHARGE   = 3'd3,
    WARP     = 3'd4,
    COOLDOWN = 3'd5
  } state_t;

  localparam logic [3:0] SEL_ZERO = 4'b0001;
  localparam logic [3:0] MODE_ATK = 4'b0010;
  localparam logic [3:0] MODE_DEF = 4'b0100;
  localparam logic [3:0] MODE_STL = 4'b1000;
  localparam logic [3:0] POS_INT  = 4'b0010;
  localparam logic [3:0] POS_WARP = 4'b0100;
  localparam logic [7:0] CHG_LAST = 8'(CHARGE_CYCLES - 1);
  localparam logic [7:0] CD_LAST  = 8'(COOLDOWN_CYCLES - 1);

  state_t     st_q, st_d, ret_st;
  logic [3:0] saved_q, saved_d, mode_d, pos_d;
  logic [7:0] cnt_q, cnt_d;
  logic       ready_q, ready_d, busy_d, err_d, accept, warp_done;

  assign accept        = cmd.cmd_valid && ready_q;
  // Leaving a warp or abort lands back where the saved mode says we were.
  assign ret_st        = (saved_q != SEL_ZERO) ? CRUISE : PARK;
  assign state         = st_q;
  assign cmd.cmd_ready = ready_q;

  // Next state, saved mode and counter, then output decode of the next state
  // so every output comes straight off a flop.
  always_comb begin
    st_d      = st_q;
    saved_d   = saved_q;
    cnt_d     = cnt_q;
    err_d     = 1'b0;
    warp_done = 1'b0;
    case (st_q)
      ZERO: st_d = PARK;
      PARK, CRUISE: begin
        if (accept) begin
          case (cmd.cmd_code)
            3'd0: begin saved_d = SEL_ZERO; st_d = PARK;   end
            3'd1: begin saved_d = MODE_ATK; st_d = CRUISE; end
            3'd2: begin saved_d = MODE_DEF; st_d = CRUISE; end
            3'd3: begin saved_d = MODE_STL; st_d = CRUISE; end
            3'd4: begin st_d = CHARGE; cnt_d = '0; end
            3'd5: begin saved_d = SEL_ZERO; st_d = ZERO;   end
            default: err_d = 1'b1;
          endcase
        end
      end
      CHARGE: begin
        // Abort beats the final charge cycle: no warp once abort is seen.
        if (abort)                  st_d = ret_st;
        else if (cnt_q == CHG_LAST) st_d = WARP;
        else                        cnt_d = cnt_q + 8'd1;
      end
      WARP: begin
        st_d      = COOLDOWN;
        cnt_d     = '0;
        warp_done = 1'b1;
      end
      COOLDOWN: begin
        if (cnt_q == CD_LAST) st_d = ret_st;
        else                  cnt_d = cnt_q + 8'd1;
      end
      default: st_d = ZERO;
    endcase

    mode_d  = SEL_ZERO;
    pos_d   = POS_INT;
    ready_d = 1'b0;
    busy_d  = 1'b0;
    case (st_d)
      ZERO:     pos_d = SEL_ZERO;
      PARK:     ready_d = 1'b1;
      CRUISE:   begin mode_d = saved_d; ready_d = 1'b1; end
      CHARGE:   busy_d = 1'b1;
      WARP:     begin pos_d = POS_WARP; busy_d = 1'b1; end
      COOLDOWN: begin mode_d = MODE_DEF; busy_d = 1'b1; end
      default:  pos_d = SEL_ZERO;
    endcase
  end

  // State, saved mode, counter and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q     <= ZERO;
      saved_q  <= SEL_ZERO;
      cnt_q    <= '0;
      ready_q  <= 1'b0;
      mode_sel <= SEL_ZERO;
      pos_sel  <= SEL_ZERO;
      busy     <= 1'b0;
      cmd_err  <= 1'b0;
    end else begin
      st_q     <= st_d;
      saved_q  <= saved_d;
      cnt_q    <= cnt_d;
      ready_q  <= ready_d;
      mode_sel <= mode_d;
      pos_sel  <= pos_d;
      busy     <= busy_d;
      cmd_err  <= err_d;
    end
  end

`ifdef FLIGHT_SEQ_WARP_COUNT_EN
  logic [7:0] wc_q;

  // Completed-warp counter, holds at 255.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                         wc_q <= '0;
    else if (warp_done && wc_q != 8'hFF) wc_q <= wc_q + 8'd1;
  end

  assign warp_count = wc_q;
`else
  logic unused_warp_done;
  assign unused_warp_done = warp_done;
  assign warp_count       = 8'd0;
`endif
endmodule
